// File: rtl/sprite_mem_arbiter_if.sv
// sprite_mem_arbiter_if
//   Bundles the requester, RAM and status signals that run between the sprite
//   move engine (r0), the CPU sprite writer (r1), the sprite RAM and the
//   arbiter.
//   master : requester/RAM side. Drives requests and mem_rdata. Receives
//            grants, rvalids, rdata, the RAM command and lock_err.
//   slave  : arbiter side. It is the mirror of master.
interface sprite_mem_arbiter_if;
  logic        r0_req;
  logic        r0_lock;
  logic        r0_we;
  logic [7:0]  r0_addr;
  logic [63:0] r0_wdata;
  logic        r0_gnt;
  logic        r0_rvalid;
  logic        r1_req;
  logic        r1_we;
  logic [7:0]  r1_addr;
  logic [63:0] r1_wdata;
  logic        r1_gnt;
  logic        r1_rvalid;
  logic [63:0] rdata;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        lock_err;

  modport master (
    output r0_req, r0_lock, r0_we, r0_addr, r0_wdata,
    input  r0_gnt, r0_rvalid,
    output r1_req, r1_we, r1_addr, r1_wdata,
    input  r1_gnt, r1_rvalid,
    input  rdata, mem_we, mem_addr, mem_wdata, lock_err,
    output mem_rdata
  );

  modport slave (
    input  r0_req, r0_lock, r0_we, r0_addr, r0_wdata,
    output r0_gnt, r0_rvalid,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    output r1_gnt, r1_rvalid,
    output rdata, mem_we, mem_addr, mem_wdata, lock_err,
    input  mem_rdata
  );
endinterface

// File: rtl/sprite_mem_arbiter.sv
// sprite_mem_arbiter
//   Shares the single-port sprite RAM (256 x 64, 1-cycle synchronous read)
//   between the move engine (r0) and the CPU sprite writer (r1).
//   - Round-robin arbitration. Requester 0 wins the first tie after reset.
//   - r0_lock keeps ownership with r0 across a read-modify-write.
//   - Lock timeout: after LOCK_MAX consecutive locked cycles with r1 pending,
//     the lock is forced free, lock_err pulses, and r1 wins the next tie.
//   - rN_rvalid is asserted one cycle after a granted read. rdata is
//     mem_rdata while an rvalid is asserted, and 0 otherwise.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : sprite_mem_arbiter_if.slave (requesters, RAM, lock_err)
//   Optional macro ARB_STATS_EN adds the following ports:
//     stat_clr (in), stat_gnt0/stat_gnt1/stat_stall1 (out, 16-bit,
//     saturating).
module sprite_mem_arbiter #(
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  sprite_mem_arbiter_if.slave bus
`ifdef ARB_STATS_EN
  ,
  input  logic                stat_clr,
  output logic [15:0]         stat_gnt0,
  output logic [15:0]         stat_gnt1,
  output logic [15:0]         stat_stall1
`endif
);

  typedef enum logic {FREE, LOCKED0} state_t;

  localparam logic [7:0] LOCK_LIM = 8'(LOCK_MAX);

  state_t     state_q, state_d;
  logic       last_gnt_q, last_gnt_d;
  logic [7:0] lock_cnt_q, lock_cnt_d;
  logic [7:0] addr_q;
  logic       rvalid0_q, rvalid1_q;
  logic       gnt0, gnt1, timeout;

  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    timeout    = 1'b0;
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    lock_cnt_d = '0;
    unique case (state_q)
      FREE: begin
        if (bus.r0_req && (!bus.r1_req || last_gnt_q)) gnt0 = 1'b1;
        else if (bus.r1_req)                           gnt1 = 1'b1;
        if (gnt0 && bus.r0_lock) state_d = LOCKED0;
      end
      LOCKED0: begin
        gnt0 = bus.r0_req;
        if (bus.r1_req) lock_cnt_d = lock_cnt_q + 8'd1;
        // The timeout cycle is the LOCK_MAX-th consecutive pending cycle.
        // r0 may still be granted in that cycle.
        if (bus.r1_req && lock_cnt_d == LOCK_LIM) begin
          timeout = 1'b1;
          state_d = FREE;
        end else if (!bus.r0_lock) begin
          // This covers both release paths: a granted access without lock,
          // and an idle r0 that has dropped the lock.
          state_d = FREE;
        end
      end
    endcase
    if (state_d == FREE) lock_cnt_d = '0;
    // No access may reach the RAM while reset is asserted.
    if (!rst_n) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
    if (gnt0)    last_gnt_d = 1'b0;
    if (gnt1)    last_gnt_d = 1'b1;
    if (timeout) last_gnt_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FREE;
      last_gnt_q <= 1'b1;
      lock_cnt_q <= '0;
      addr_q     <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      lock_cnt_q <= lock_cnt_d;
      addr_q     <= bus.mem_addr;
      rvalid0_q  <= gnt0 & ~bus.r0_we;
      rvalid1_q  <= gnt1 & ~bus.r1_we;
    end
  end

  always_comb begin
    bus.r0_gnt    = gnt0;
    bus.r1_gnt    = gnt1;
    bus.r0_rvalid = rvalid0_q;
    bus.r1_rvalid = rvalid1_q;
    bus.rdata     = (rvalid0_q | rvalid1_q) ? bus.mem_rdata : '0;
    bus.lock_err  = timeout;
    bus.mem_we    = (gnt0 & bus.r0_we) | (gnt1 & bus.r1_we);
    bus.mem_addr  = gnt0 ? bus.r0_addr : (gnt1 ? bus.r1_addr : addr_q);
    bus.mem_wdata = gnt0 ? bus.r0_wdata : (gnt1 ? bus.r1_wdata : '0);
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_gnt0   <= '0;
      stat_gnt1   <= '0;
      stat_stall1 <= '0;
    end else if (stat_clr) begin
      stat_gnt0   <= '0;
      stat_gnt1   <= '0;
      stat_stall1 <= '0;
    end else begin
      if (gnt0 && stat_gnt0 != '1)                  stat_gnt0   <= stat_gnt0 + 16'd1;
      if (gnt1 && stat_gnt1 != '1)                  stat_gnt1   <= stat_gnt1 + 16'd1;
      if (bus.r1_req && !gnt1 && stat_stall1 != '1) stat_stall1 <= stat_stall1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sprite_mem_arbiter.sv
module tb_sprite_mem_arbiter;
  localparam int unsigned LM = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sprite_mem_arbiter_if bus();

`ifdef ARB_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] stat_gnt0, stat_gnt1, stat_stall1;
`endif

  sprite_mem_arbiter #(.LOCK_MAX(LM)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus)
`ifdef ARB_STATS_EN
    ,
    .stat_clr   (stat_clr),
    .stat_gnt0  (stat_gnt0),
    .stat_gnt1  (stat_gnt1),
    .stat_stall1(stat_stall1)
`endif
  );

  // Sprite RAM: synchronous read, read-before-write.
  logic [63:0] ram [256];
  logic [63:0] ram_q = '0;
  assign bus.mem_rdata = ram_q;
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    ram_q <= ram[bus.mem_addr];
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. It holds the owner (-1 free, 0 locked by r0), the
  // requester that won last, the number of cycles r1 has waited under the
  // lock, the last RAM address, pending read returns and the expected RAM
  // contents.
  int          m_owner = -1, m_last = 1, m_wait = 0;
  logic [7:0]  m_addr = '0;
  bit          m_rv0 = 0, m_rv1 = 0;
  logic [63:0] m_rdata = '0;
  logic [63:0] shadow [256];
  int          n_owner, n_last, n_wait;
  logic [7:0]  n_addr;
  bit          n_rv0, n_rv1, n_we, n_valid = 0;
  logic [63:0] n_rdata, n_wdata;

  always @(negedge clk) begin : model_cmp
    int win;
    bit err, we;
    logic [7:0] a;
    logic [63:0] wd;
    if (!rst_n) begin
      m_owner = -1; m_last = 1; m_wait = 0; m_addr = '0; m_rv0 = 0; m_rv1 = 0;
    end
    win = -1;
    err = 0;
    if (rst_n) begin
      if (m_owner == 0) begin
        if (bus.r0_req) win = 0;
        if (bus.r1_req && m_wait + 1 >= LM) err = 1;
      end else if (bus.r0_req && bus.r1_req) win = (m_last == 0) ? 1 : 0;
      else if (bus.r0_req) win = 0;
      else if (bus.r1_req) win = 1;
    end
    we = 0; a = m_addr; wd = '0;
    if (win == 0) begin we = bus.r0_we; a = bus.r0_addr; wd = bus.r0_wdata; end
    if (win == 1) begin we = bus.r1_we; a = bus.r1_addr; wd = bus.r1_wdata; end

    check("m_gnt0", bus.r0_gnt, win == 0);
    check("m_gnt1", bus.r1_gnt, win == 1);
    check("m_lock_err", bus.lock_err, err);
    check("m_mem_we", bus.mem_we, we);
    check("m_mem_addr", bus.mem_addr, a);
    if (we) check("m_mem_wdata", bus.mem_wdata, wd);
    check("m_rvalid0", bus.r0_rvalid, m_rv0);
    check("m_rvalid1", bus.r1_rvalid, m_rv1);
    check("m_rdata", bus.rdata, (m_rv0 || m_rv1) ? m_rdata : 64'd0);

    n_addr  = a;
    n_rv0   = (win == 0) && !bus.r0_we;
    n_rv1   = (win == 1) && !bus.r1_we;
    n_rdata = shadow[a];
    n_we    = we;
    n_wdata = wd;
    n_last  = (win >= 0) ? win : m_last;
    if (err) n_last = 0;
    n_owner = m_owner;
    n_wait  = 0;
    if (m_owner == 0) begin
      if (err || !bus.r0_lock) n_owner = -1;
      else if (bus.r1_req)     n_wait = m_wait + 1;
    end else if (win == 0 && bus.r0_lock) begin
      n_owner = 0;
    end
    n_valid = rst_n;
  end

  always @(posedge clk) begin
    if (n_valid && rst_n) begin
      if (n_we) shadow[n_addr] = n_wdata;
      m_owner = n_owner; m_last = n_last; m_wait = n_wait; m_addr = n_addr;
      m_rv0 = n_rv0; m_rv1 = n_rv1; m_rdata = n_rdata;
    end
  end

  task automatic set0(input logic req, input logic lock, input logic we,
                      input logic [7:0] addr, input logic [63:0] wdata);
    bus.r0_req = req; bus.r0_lock = lock; bus.r0_we = we;
    bus.r0_addr = addr; bus.r0_wdata = wdata;
  endtask

  task automatic set1(input logic req, input logic we,
                      input logic [7:0] addr, input logic [63:0] wdata);
    bus.r1_req = req; bus.r1_we = we; bus.r1_addr = addr; bus.r1_wdata = wdata;
  endtask

  task automatic idle;
    set0(0, 0, 0, '0, '0);
    set1(0, 0, '0, '0);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    idle();
    step();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : directed
    int n;
    logic [5:0] pat;
    for (int i = 0; i < 256; i++) begin
      ram[i]    = 64'h1111_0000_0000_0000 + 64'(i);
      shadow[i] = 64'h1111_0000_0000_0000 + 64'(i);
    end
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt0", bus.r0_gnt, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_lock_err", bus.lock_err, 0);
    check("rst_rvalid0", bus.r0_rvalid, 0);

    // First read after reset.
    step();
    rst_n = 1'b1;
    set0(1, 0, 0, 8'h02, '0);
    @(negedge clk);
    check("t1_gnt0", bus.r0_gnt, 1);
    check("t1_addr", bus.mem_addr, 8'h02);
    step();
    idle();
    @(negedge clk);
    check("t1_rvalid0", bus.r0_rvalid, 1);
    check("t1_rdata", bus.rdata, 64'h1111_0000_0000_0002);

    // Alternating grants with both requesters active.
    do_reset();
    set0(1, 0, 0, 8'h10, '0);
    set1(1, 0, 8'h20, '0);
    pat = 6'b101010;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("t2_gnt0", bus.r0_gnt, !pat[k]);
      check("t2_gnt1", bus.r1_gnt, pat[k]);
      if (k > 0) check("t2_rvalid0", bus.r0_rvalid, pat[k]);
      step();
    end
    idle();

    // Locked read-modify-write while r1 waits to write the same entry.
    step();
    set0(1, 1, 0, 8'h01, '0);
    set1(1, 1, 8'h01, 64'hDEAD_BEEF_0000_0001);
    @(negedge clk);
    check("t3_gnt0_a", bus.r0_gnt, 1);
    check("t3_gnt1_a", bus.r1_gnt, 0);
    step();
    set0(0, 1, 0, 8'h01, '0);
    @(negedge clk);
    check("t3_gnt1_b", bus.r1_gnt, 0);
    check("t3_rdata", bus.rdata, 64'h1111_0000_0000_0001);
    step();
    set0(1, 0, 1, 8'h01, 64'h5555_0000_0000_0001);
    @(negedge clk);
    check("t3_gnt0_c", bus.r0_gnt, 1);
    check("t3_gnt1_c", bus.r1_gnt, 0);
    step();
    set0(0, 0, 0, '0, '0);
    @(negedge clk);
    check("t3_gnt1_d", bus.r1_gnt, 1);
    step();
    idle();
    step();
    @(negedge clk);
    check("t3_ram1", ram[1], 64'hDEAD_BEEF_0000_0001);

    // Lock timeout with r0 idle but still holding the lock.
    step();
    set0(1, 1, 0, 8'h05, '0);
    @(negedge clk);
    check("t4_gnt0", bus.r0_gnt, 1);
    step();
    set0(0, 1, 0, 8'h05, '0);
    set1(1, 1, 8'h06, 64'hCAFE_0000_0000_0006);
    n = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.lock_err) begin
        n = c;
        break;
      end
      step();
    end
    check("t4_err_cycle", n, 4);
    step();
    set0(0, 0, 0, '0, '0);
    @(negedge clk);
    check("t4_gnt1_after", bus.r1_gnt, 1);
    check("t4_err_pulse", bus.lock_err, 0);
    step();
    idle();

    // A read by r0 in the timeout cycle still returns its data.
    step();
    set0(1, 1, 0, 8'h05, '0);
    @(negedge clk);
    check("t4b_gnt0", bus.r0_gnt, 1);
    step();
    set0(0, 1, 0, 8'h05, '0);
    set1(1, 1, 8'h16, 64'hCAFE_0000_0000_0016);
    repeat (3) begin
      @(negedge clk);
      step();
    end
    set0(1, 1, 0, 8'h07, '0);
    @(negedge clk);
    check("t4b_gnt0_to", bus.r0_gnt, 1);
    check("t4b_err", bus.lock_err, 1);
    step();
    set0(0, 0, 0, '0, '0);
    @(negedge clk);
    check("t4b_rvalid0", bus.r0_rvalid, 1);
    check("t4b_rdata", bus.rdata, 64'h1111_0000_0000_0007);
    check("t4b_gnt1", bus.r1_gnt, 1);
    step();
    idle();

    // Reset one cycle after a locked read.
    step();
    set0(1, 1, 0, 8'h03, '0);
    @(negedge clk);
    check("t5_gnt0", bus.r0_gnt, 1);
    step();
    rst_n = 1'b0;
    set0(0, 0, 0, '0, '0);
    set1(1, 1, 8'h09, 64'hBAD0_0000_0000_0009);
    @(negedge clk);
    check("t5_rvalid0", bus.r0_rvalid, 0);
    check("t5_mem_we", bus.mem_we, 0);
    check("t5_gnt1_rst", bus.r1_gnt, 0);
    step();
    @(negedge clk);
    check("t5_mem_we2", bus.mem_we, 0);
    step();
    rst_n = 1'b1;
    set1(1, 0, 8'h09, '0);
    @(negedge clk);
    check("t5_gnt1_free", bus.r1_gnt, 1);
    step();
    idle();
    @(negedge clk);
    check("t5_rvalid1", bus.r1_rvalid, 1);
    check("t5_ram9", bus.rdata, 64'h1111_0000_0000_0009);

`ifdef ARB_STATS_EN
    // Statistics: r1 stalls during a three-cycle lock, then writes ten times.
    do_reset();
    set0(1, 1, 0, 8'h04, '0);
    set1(1, 1, 8'h40, 64'h7700);
    step();
    set0(0, 1, 0, 8'h04, '0);
    step();
    set0(1, 0, 1, 8'h04, 64'h88);
    step();
    set0(0, 0, 0, '0, '0);
    for (int k = 0; k < 10; k++) begin
      set1(1, 1, 8'h40 + 8'(k), 64'h7700 + 64'(k));
      step();
    end
    idle();
    @(negedge clk);
    check("st_gnt1", stat_gnt1, 10);
    check("st_stall1", stat_stall1, 3);
    check("st_gnt0", stat_gnt0, 2);
    step();
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    @(negedge clk);
    check("st_clr_gnt0", stat_gnt0, 0);
    check("st_clr_gnt1", stat_gnt1, 0);
    check("st_clr_stall1", stat_stall1, 0);
`endif

    step();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
